if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble encoding loaded into IF/ID.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  reset, active low.
REQ-004 SHALL have stall  input  1  hazard hold; freezes PC and IF/ID.
REQ-005 SHALL have if_id_flush  input  1  taken branch resolved in ID; redirect fetch.
REQ-006 SHALL have branch_target  input  32  redirect address, valid with if_id_flush.
REQ-007 SHALL have imem_req_valid  output  1, imem_req_ready  input  1, imem_addr  output  32  fetch request handshake.
REQ-008 SHALL have imem_rsp_valid  input  1, imem_rdata  input  32  fetch response, one cycle pulse.
REQ-009 SHALL have if_id_pc  output  32, if_id_instr  output  32, if_id_valid  output  1  IF/ID register contents.

Function
REQ-010 SHALL run FSM states FETCH (imem_req_valid=1, imem_addr=pc), WAIT (one request outstanding, imem_req_valid=0) and FULL (response held in buffer, imem_req_valid=0).
REQ-011 FETCH: on imem_req_ready=1 SHALL set req_pc<=pc, pc<=pc+4 and go to WAIT; otherwise hold imem_addr stable.
REQ-012 WAIT, imem_rsp_valid=1, stall=0: SHALL load IF/ID with {req_pc, imem_rdata, valid=1}, go to FETCH; response visible on outputs the next cycle (1-cycle latency).
REQ-013 WAIT, imem_rsp_valid=1, stall=1: SHALL capture {req_pc, imem_rdata} in a 1-entry buffer and go to FULL.
REQ-014 FULL, stall=0: SHALL load IF/ID from the buffer with valid=1 and go to FETCH.
REQ-015 Any cycle with stall=0, no flush and no instruction loaded: SHALL load IF/ID with {pc unchanged, NOP_INSTR, valid=0}.
REQ-016 stall=1 without flush: SHALL hold pc, IF/ID and buffer unchanged; a FETCH handshake still completes per REQ-011.
REQ-017 if_id_flush=1 SHALL take priority over stall: IF/ID<={branch_target, NOP_INSTR, 0}, pc<={branch_target[31:2],2'b00}, buffer discarded.
REQ-018 Flush in FETCH: if the handshake completes that cycle, SHALL go to WAIT with drop flag set; else stay in FETCH; imem_addr changes to the target next cycle (sole exception to address stability).
REQ-019 Flush in WAIT: SHALL set drop flag, or if imem_rsp_valid=1 the same cycle discard that response and go to FETCH; flush in FULL SHALL go to FETCH.
REQ-020 Response arriving with drop flag set SHALL be discarded, clear the flag, go to FETCH, and leave IF/ID untouched.
REQ-021 imem_rsp_valid in FETCH or FULL SHALL be ignored.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-023 rst_n=0 SHALL immediately force: state FETCH, pc=RESET_PC, req_pc=0, drop flag=0, buffer empty, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0; imem_req_valid=1 from the first cycle after release.
REQ-024 Reset asserted mid-transaction SHALL abandon the outstanding request; its late response falls under REQ-021.

Configuration
REQ-025 With IF_PERF_CNT_EN defined SHALL add output perf_bubble_cnt (32) counting cycles in which a bubble is loaded per REQ-015/REQ-017, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-026 Without IF_PERF_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-027 Zero-wait memory (ready=1, rsp one cycle after accept) from reset -> if_id_pc sequence 0,4,8 with valid=1 every other cycle, NOP bubbles between.
REQ-028 stall=1 for 3 cycles while in WAIT, rsp at addr 0x8 -> FULL; IF/ID held; one cycle after stall drops, if_id_pc=0x8 with matching rdata.
REQ-029 if_id_flush=1 with branch_target=0x103 while in WAIT -> next imem_addr=0x100; stale response dropped; first valid if_id_pc=0x100.
REQ-030 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-031 rst_n low for one cycle mid-WAIT, late rsp_valid after release -> ignored; imem_addr=RESET_PC, if_id_valid=0.
REQ-032 IF_PERF_CNT_EN defined, 5 bubble cycles then reset -> perf_bubble_cnt=5 then 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM with a 1-entry skid buffer feeding IF/ID.
// Optional bubble counter enabled by defining IF_PERF_CNT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | request driven on imem, address = pc
// S_WAIT  | one request outstanding, waiting for the response
// S_FULL  | response captured during a stall, held in the skid buffer
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        if_id_flush,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, req_pc_q, buf_pc_q, buf_instr_q;
  logic        drop_q;
  logic        req_fire, rsp_take, rsp_keep, load_rsp, load_buf, load_bubble;

  assign req_fire    = (state_q == S_FETCH) && imem_req_ready;
  assign rsp_take    = (state_q == S_WAIT) && imem_rsp_valid;
  assign rsp_keep    = rsp_take && !drop_q && !if_id_flush;
  assign load_rsp    = rsp_keep && !stall;
  assign load_buf    = (state_q == S_FULL) && !stall && !if_id_flush;
  assign load_bubble = if_id_flush || (!stall && !load_rsp && !load_buf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (rsp_take) state_d = (rsp_keep && stall) ? S_FULL : S_FETCH;
      S_FULL:  if (if_id_flush || !stall) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == S_FETCH);
    imem_addr      = pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      drop_q      <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_instr_q <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      if (req_fire) req_pc_q <= pc_q;

      if (if_id_flush)   pc_q <= {branch_target[31:2], 2'b00};
      else if (req_fire) pc_q <= pc_q + 32'd4;

      // A flush orphans any request still in flight, including one accepted this very cycle.
      if (if_id_flush)   drop_q <= ((state_q == S_WAIT) && !imem_rsp_valid) || req_fire;
      else if (rsp_take) drop_q <= 1'b0;

      if (rsp_keep && stall) begin
        buf_pc_q    <= req_pc_q;
        buf_instr_q <= imem_rdata;
      end

      if (load_rsp) begin
        if_id_pc    <= req_pc_q;
        if_id_instr <= imem_rdata;
        if_id_valid <= 1'b1;
      end else if (load_buf) begin
        if_id_pc    <= buf_pc_q;
        if_id_instr <= buf_instr_q;
        if_id_valid <= 1'b1;
      end else if (if_id_flush) begin
        if_id_pc    <= branch_target;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (load_bubble) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         perf_bubble_cnt <= 32'h0;
    else if (load_bubble && (perf_bubble_cnt != '1))    perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, reset/perf sequences,
// and randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        if_id_flush = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req_valid, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .if_id_flush    (if_id_flush),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  typedef struct {
    bit st; bit fl; logic [31:0] tgt; bit rdy; bit rv; logic [31:0] rd;
    bit e_rv; logic [31:0] e_addr; logic [31:0] e_pc; logic [31:0] e_instr; bit e_v;
  } vec_t;
  vec_t vecs[29];

  typedef struct { logic [31:0] addr; bit dropped; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  req_t        inflight[$];
  ent_t        held[$];
  logic [31:0] m_pc, m_ipc, m_iin;
  bit          m_iv;

  task automatic check(input string name, input bit erv, input logic [31:0] eaddr,
                       input logic [31:0] epc, input logic [31:0] einstr, input bit ev);
    checks++;
    if ({imem_req_valid, imem_addr, if_id_pc, if_id_instr, if_id_valid} !== {erv, eaddr, epc, einstr, ev}) begin
      errors++;
      $display("FAIL %s: got rv=%0b addr=%h pc=%h instr=%h v=%0b, want rv=%0b addr=%h pc=%h instr=%h v=%0b",
               name, imem_req_valid, imem_addr, if_id_pc, if_id_instr, if_id_valid, erv, eaddr, epc, einstr, ev);
    end
  endtask

  task automatic drive(input bit st, input bit fl, input logic [31:0] tgt,
                       input bit rdy, input bit rv, input logic [31:0] rd);
    stall = st; if_id_flush = fl; branch_target = tgt;
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rdata = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(O, O, 32'h0, O, O, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: fetch may issue only when nothing is in flight and nothing is held.
  task automatic model_step(input bit st, input bit fl, input logic [31:0] tgt,
                            input bit rdy, input bit rv, input logic [31:0] rd);
    bit   can_issue, accepted, rsp_seen, loaded;
    req_t r;
    can_issue = (inflight.size() == 0) && (held.size() == 0);
    accepted  = can_issue && rdy;
    rsp_seen  = (inflight.size() != 0) && rv;
    loaded    = 1'b0;
    if (fl) begin
      m_ipc = tgt; m_iin = NOP; m_iv = 1'b0;
      held.delete();
      if (rsp_seen) void'(inflight.pop_front());
      else foreach (inflight[k]) inflight[k].dropped = 1'b1;
      if (accepted) inflight.push_back('{m_pc, 1'b1});
      m_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (rsp_seen) begin
        r = inflight.pop_front();
        if (!r.dropped) begin
          if (st) held.push_back('{r.addr, rd});
          else begin m_ipc = r.addr; m_iin = rd; m_iv = 1'b1; loaded = 1'b1; end
        end
      end else if ((held.size() != 0) && !st) begin
        m_ipc = held[0].pc; m_iin = held[0].instr; m_iv = 1'b1; loaded = 1'b1;
        held.delete();
      end
      if (accepted) begin
        inflight.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (!st && !loaded) begin m_iin = NOP; m_iv = 1'b0; end
    end
  endtask

  initial begin
    vecs[0]  = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h0,         32'h0,         NOP,           O};
    vecs[1]  = '{O, O, 32'h0,         O, I, 32'hA000_0000, O, 32'h4,         32'h0,         NOP,           O};
    vecs[2]  = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h4,         32'h0,         32'hA000_0000, I};
    vecs[3]  = '{O, O, 32'h0,         O, I, 32'hA000_0004, O, 32'h8,         32'h0,         NOP,           O};
    vecs[4]  = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h8,         32'h4,         32'hA000_0004, I};
    vecs[5]  = '{I, O, 32'h0,         O, I, 32'hA000_0008, O, 32'hC,         32'h4,         NOP,           O};
    vecs[6]  = '{I, O, 32'h0,         O, O, 32'h0,         O, 32'hC,         32'h4,         NOP,           O};
    vecs[7]  = '{I, O, 32'h0,         O, O, 32'h0,         O, 32'hC,         32'h4,         NOP,           O};
    vecs[8]  = '{O, O, 32'h0,         O, O, 32'h0,         O, 32'hC,         32'h4,         NOP,           O};
    vecs[9]  = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'hC,         32'h8,         32'hA000_0008, I};
    vecs[10] = '{O, I, 32'h103,       O, O, 32'h0,         O, 32'h10,        32'h8,         NOP,           O};
    vecs[11] = '{O, O, 32'h0,         O, I, 32'hDEAD_BEEF, O, 32'h100,       32'h103,       NOP,           O};
    vecs[12] = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h100,       32'h103,       NOP,           O};
    vecs[13] = '{O, O, 32'h0,         O, I, 32'hB000_0000, O, 32'h104,       32'h103,       NOP,           O};
    vecs[14] = '{O, O, 32'h0,         O, O, 32'h0,         I, 32'h104,       32'h100,       32'hB000_0000, I};
    vecs[15] = '{O, O, 32'h0,         O, I, 32'hEEEE_EEEE, I, 32'h104,       32'h100,       NOP,           O};
    vecs[16] = '{O, I, 32'hFFFF_FFFC, I, O, 32'h0,         I, 32'h104,       32'h100,       NOP,           O};
    vecs[17] = '{O, O, 32'h0,         O, I, 32'hDDDD_DDDD, O, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           O};
    vecs[18] = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           O};
    vecs[19] = '{O, O, 32'h0,         O, I, 32'hC000_0000, O, 32'h0,         32'hFFFF_FFFC, NOP,           O};
    vecs[20] = '{O, I, 32'h200,       O, O, 32'h0,         I, 32'h0,         32'hFFFF_FFFC, 32'hC000_0000, I};
    vecs[21] = '{I, O, 32'h0,         I, O, 32'h0,         I, 32'h200,       32'h200,       NOP,           O};
    vecs[22] = '{I, O, 32'h0,         O, I, 32'hD000_0000, O, 32'h204,       32'h200,       NOP,           O};
    vecs[23] = '{I, I, 32'h300,       O, O, 32'h0,         O, 32'h204,       32'h200,       NOP,           O};
    vecs[24] = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h300,       32'h300,       NOP,           O};
    vecs[25] = '{O, I, 32'h400,       O, I, 32'hE000_0000, O, 32'h304,       32'h300,       NOP,           O};
    vecs[26] = '{O, O, 32'h0,         I, O, 32'h0,         I, 32'h400,       32'h400,       NOP,           O};
    vecs[27] = '{O, O, 32'h0,         O, I, 32'hF000_0000, O, 32'h404,       32'h400,       NOP,           O};
    vecs[28] = '{O, O, 32'h0,         O, O, 32'h0,         I, 32'h404,       32'h400,       32'hF000_0000, I};

    // Directed table: outputs checked first, then the row's inputs applied for the next edge.
    do_reset();
    for (int i = 0; i < 29; i++) begin
      check($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_v);
      drive(vecs[i].st, vecs[i].fl, vecs[i].tgt, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
      @(negedge clk);
    end

    // Reset asserted mid-WAIT: async clear, then a late response must be ignored.
    do_reset();
    drive(O, O, 32'h0, I, O, 32'h0);
    @(negedge clk);
    drive(O, O, 32'h0, O, O, 32'h0);
    check("mid_wait", O, 32'h4, 32'h0, NOP, O);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", I, 32'h0, 32'h0, NOP, O);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(O, O, 32'h0, O, I, 32'h5555_5555);
    @(negedge clk);
    drive(O, O, 32'h0, O, O, 32'h0);
    check("late_rsp_ignored", I, 32'h0, 32'h0, NOP, O);

`ifdef IF_PERF_CNT_EN
    do_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (perf_bubble_cnt !== 32'd5) begin
      errors++;
      $display("FAIL perf_cnt_5: got %0d want 5", perf_bubble_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (perf_bubble_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_cnt_reset: got %0d want 0", perf_bubble_cnt);
    end
`endif

    // Randomized traffic against the reference model.
    do_reset();
    inflight.delete();
    held.delete();
    m_pc = 32'h0; m_ipc = 32'h0; m_iin = NOP; m_iv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit          st, fl, rdy, rv;
      logic [31:0] tgt, rd;
      check("rand", (inflight.size() == 0) && (held.size() == 0), m_pc, m_ipc, m_iin, m_iv);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      rdy = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 1) == 1);
      rd  = $urandom;
      drive(st, fl, tgt, rdy, rv, rd);
      model_step(st, fl, tgt, rdy, rv, rd);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
